hand_bank: RTL and testbench

Parametrised card-hand register bank for the baccarat datapath, generalising the fixed three-register-per-player arrangement to NUM_HANDS hands of CARDS_PER_HAND slots each. Cards arrive one at a time over a valid/ready handshake with a target hand index. Each hand keeps its own fill pointer, full flag and a registered running score (mod 10). The controller then reads scores directly and no longer needs one load strobe per slot.

---
 rtl/hand_bank.sv | 145 ++++++++++++++
 tb/tb_hand_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hand_bank.sv
// Card-hand register bank: NUM_HANDS hands of CARDS_PER_HAND slots, fed one card per cycle.
// Optional natural-hand detect is built only when HAND_BANK_NATURAL_EN is defined.

module hand_bank_hand #(
  parameter int C  = 3,
  parameter int CW = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [3:0]        card_i,
  input  logic [3:0]        val_i,
  output logic [C-1:0][3:0] cards_o,
  output logic [CW-1:0]     count_o,
  output logic [3:0]        score_o,
  output logic              full_o,
  output logic              natural_o
);
  logic [C-1:0][3:0] cards_q;
  logic [CW-1:0]     count_q, count_d;
  logic [3:0]        score_q, score_d;
  logic              full_q;
  logic [4:0]        sum;

  // 5-bit sum keeps the mod-10 fold exact for any score/val pair
  assign sum     = {1'b0, score_q} + {1'b0, val_i};
  assign score_d = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
  assign count_d = count_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cards_q <= '0;
      count_q <= '0;
      score_q <= '0;
      full_q  <= 1'b0;
    end else if (clear_i) begin
      cards_q <= '0;
      count_q <= '0;
      score_q <= '0;
      full_q  <= 1'b0;
    end else if (load_i) begin
      for (int k = 0; k < C; k++)
        if (count_q == CW'(k)) cards_q[k] <= card_i;
      count_q <= count_d;
      score_q <= score_d;
      full_q  <= (count_q == CW'(C-1));
    end
  end

`ifdef HAND_BANK_NATURAL_EN
  logic natural_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      natural_q <= 1'b0;
    else if (clear_i)
      natural_q <= 1'b0;
    else if (load_i && count_q == CW'(1) && score_d >= 4'd8)
      natural_q <= 1'b1;
  end
  assign natural_o = natural_q;
`else
  assign natural_o = 1'b0;
`endif

  assign cards_o = cards_q;
  assign count_o = count_q;
  assign score_o = score_q;
  assign full_o  = full_q;
endmodule

module hand_bank #(
  parameter int NUM_HANDS      = 2,
  parameter int CARDS_PER_HAND = 3,
  parameter int HW             = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  parameter int CW             = $clog2(CARDS_PER_HAND + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              load_valid_i,
  input  logic [HW-1:0]                     load_hand_i,
  input  logic [3:0]                        new_card_i,
  output logic                              load_ready_o,
  output logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] cards_o,
  output logic [NUM_HANDS*CW-1:0]           count_o,
  output logic [NUM_HANDS*4-1:0]            score_o,
  output logic [NUM_HANDS-1:0]              full_o,
  output logic [NUM_HANDS-1:0]              natural_o,
  output logic                              err_o
);
  logic [NUM_HANDS-1:0][CARDS_PER_HAND-1:0][3:0] cards_w;
  logic [NUM_HANDS-1:0][CW-1:0]                  count_w;
  logic [NUM_HANDS-1:0][3:0]                     score_w;
  logic [NUM_HANDS-1:0]                          full_w, natural_w, load_w;
  logic       hand_ok, legal, accept, sel_full, err_q;
  logic [3:0] val;

  assign hand_ok = ({1'b0, load_hand_i} < (HW+1)'(NUM_HANDS));
  assign legal   = (new_card_i != 4'd0) && (new_card_i <= 4'd13);
  assign val     = (new_card_i <= 4'd9) ? new_card_i : 4'd0;

  always_comb begin
    sel_full = 1'b0;
    for (int h = 0; h < NUM_HANDS; h++)
      if (load_hand_i == HW'(h)) sel_full = full_w[h];
  end

  // Out-of-range index is always ready so a bad offer drains instead of stalling
  assign load_ready_o = hand_ok ? ~sel_full : 1'b1;
  assign accept       = load_valid_i & load_ready_o & ~clear_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      err_q <= 1'b0;
    else if (clear_i)
      err_q <= 1'b0;
    else if (accept && (!legal || !hand_ok))
      err_q <= 1'b1;
  end

  for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
    assign load_w[h] = accept & legal & hand_ok & (load_hand_i == HW'(h));
    hand_bank_hand #(.C(CARDS_PER_HAND), .CW(CW)) u_hand (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (clear_i),
      .load_i   (load_w[h]),
      .card_i   (new_card_i),
      .val_i    (val),
      .cards_o  (cards_w[h]),
      .count_o  (count_w[h]),
      .score_o  (score_w[h]),
      .full_o   (full_w[h]),
      .natural_o(natural_w[h])
    );
  end

  assign cards_o   = cards_w;
  assign count_o   = count_w;
  assign score_o   = score_w;
  assign full_o    = full_w;
  assign natural_o = natural_w;
  assign err_o     = err_q;
endmodule

// File: tb/tb_hand_bank.sv
// Randomized and directed bench for hand_bank; hand contents modelled as card lists per hand.
module tb_hand_bank;
  localparam int NH = 3, C = 3;

  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic        a_clear = 0, a_lv = 0;
  logic [1:0]  a_lh = 0;
  logic [3:0]  a_nc = 0;
  logic        a_ready, a_err;
  logic [35:0] a_cards;
  logic [5:0]  a_count;
  logic [11:0] a_score;
  logic [2:0]  a_full, a_nat;

  logic        b_clear = 0, b_lv = 0;
  logic [1:0]  b_lh = 0;
  logic [3:0]  b_nc = 0;
  logic        b_ready, b_err;
  logic [79:0] b_cards;
  logic [11:0] b_count;
  logic [15:0] b_score;
  logic [3:0]  b_full, b_nat;

  hand_bank #(.NUM_HANDS(NH), .CARDS_PER_HAND(C)) u_a (
    .clk_i(clk), .rst_i(rst), .clear_i(a_clear), .load_valid_i(a_lv),
    .load_hand_i(a_lh), .new_card_i(a_nc), .load_ready_o(a_ready),
    .cards_o(a_cards), .count_o(a_count), .score_o(a_score),
    .full_o(a_full), .natural_o(a_nat), .err_o(a_err));

  hand_bank #(.NUM_HANDS(4), .CARDS_PER_HAND(5)) u_b (
    .clk_i(clk), .rst_i(rst), .clear_i(b_clear), .load_valid_i(b_lv),
    .load_hand_i(b_lh), .new_card_i(b_nc), .load_ready_o(b_ready),
    .cards_o(b_cards), .count_o(b_count), .score_o(b_score),
    .full_o(b_full), .natural_o(b_nat), .err_o(b_err));

  int checks = 0, passes = 0;

  // reference model: list of cards held per hand plus sticky error
  int m_cards[NH][C];
  int m_cnt[NH];
  bit m_err;

  function automatic int valf(input int c);
    return (c <= 9) ? c : 0;
  endfunction

  task automatic m_clear();
    for (int h = 0; h < NH; h++) begin
      m_cnt[h] = 0;
      for (int k = 0; k < C; k++) m_cards[h][k] = 0;
    end
    m_err = 0;
  endtask

  // one cycle on DUT A: drive, check ready, advance model, check all outputs
  task automatic cyc(input bit v, input int h, input int c, input bit clr, input string nm);
    bit er, acc;
    logic [35:0] ec; logic [5:0] ecn; logic [11:0] es; logic [2:0] ef, en;
    int s;
    @(negedge clk);
    a_lv = v; a_lh = h[1:0]; a_nc = c[3:0]; a_clear = clr;
    #1;
    er = (h >= NH) ? 1'b1 : (m_cnt[h] < C);
    checks++;
    if (a_ready !== er) $display("FAIL %s ready got %0b want %0b", nm, a_ready, er);
    else passes++;
    @(posedge clk);
    acc = v && er && !clr;
    if (clr) m_clear();
    else if (acc) begin
      if (h < NH && c >= 1 && c <= 13) begin
        m_cards[h][m_cnt[h]] = c;
        m_cnt[h]++;
      end else m_err = 1;
    end
    #1;
    ec = '0; ecn = '0; es = '0; ef = '0; en = '0;
    for (int hh = 0; hh < NH; hh++) begin
      s = 0;
      for (int k = 0; k < m_cnt[hh]; k++) begin
        ec[(hh*C+k)*4 +: 4] = m_cards[hh][k][3:0];
        s += valf(m_cards[hh][k]);
      end
      ecn[hh*2 +: 2] = m_cnt[hh][1:0];
      es[hh*4 +: 4] = 4'(s % 10);
      ef[hh] = (m_cnt[hh] == C);
`ifdef HAND_BANK_NATURAL_EN
      en[hh] = (m_cnt[hh] >= 2) && ((valf(m_cards[hh][0]) + valf(m_cards[hh][1])) % 10 >= 8);
`endif
    end
    checks++; if (a_cards !== ec) $display("FAIL %s cards got %h want %h", nm, a_cards, ec); else passes++;
    checks++; if (a_count !== ecn) $display("FAIL %s count got %h want %h", nm, a_count, ecn); else passes++;
    checks++; if (a_score !== es) $display("FAIL %s score got %h want %h", nm, a_score, es); else passes++;
    checks++; if (a_full !== ef) $display("FAIL %s full got %b want %b", nm, a_full, ef); else passes++;
    checks++; if (a_nat !== en) $display("FAIL %s natural got %b want %b", nm, a_nat, en); else passes++;
    checks++; if (a_err !== m_err) $display("FAIL %s err got %b want %b", nm, a_err, m_err); else passes++;
  endtask

  task automatic test_reset();
    m_clear();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_cards, a_count, a_score, a_full, a_nat, a_err} !== '0)
      $display("FAIL reset_outputs got %h want 0", {a_cards, a_count, a_score, a_full, a_nat, a_err});
    else passes++;
    a_lv = 1; #1;
    checks++; if (a_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", a_ready); else passes++;
    a_lv = 0;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_fill();
    cyc(1, 0, 7, 0, "fill0");
    cyc(1, 0, 13, 0, "fill1");
    cyc(1, 0, 5, 0, "fill2");
    checks++; if (a_cards[11:0] !== 12'h5D7) $display("FAIL fill_cards got %h want 5d7", a_cards[11:0]); else passes++;
    checks++; if (a_score[3:0] !== 4'd2) $display("FAIL fill_score got %0d want 2", a_score[3:0]); else passes++;
    cyc(1, 0, 9, 0, "fill_full_offer");
    checks++; if (a_count[1:0] !== 2'd3) $display("FAIL fill_count got %0d want 3", a_count[1:0]); else passes++;
  endtask

  task automatic test_natural();
    cyc(1, 1, 9, 0, "nat0");
    cyc(0, 0, 0, 0, "nat_idle");
    cyc(1, 1, 9, 0, "nat1");
    checks++; if (a_score[7:4] !== 4'd8) $display("FAIL nat_score got %0d want 8", a_score[7:4]); else passes++;
  endtask

  task automatic test_err();
    cyc(1, 2, 14, 0, "err_card");
    cyc(1, 3, 4, 0, "err_hand");
    cyc(0, 0, 0, 0, "err_hold0");
    cyc(1, 2, 0, 0, "err_card0");
    checks++; if (a_err !== 1'b1) $display("FAIL err_sticky got %b want 1", a_err); else passes++;
  endtask

  task automatic test_clear_collision();
    cyc(1, 2, 3, 0, "clr_pre");
    cyc(1, 0, 4, 1, "clr_collide");
    checks++;
    if ({a_cards, a_count, a_score, a_err} !== '0) $display("FAIL clr_all got %h want 0", {a_cards, a_count, a_score, a_err});
    else passes++;
  endtask

  task automatic test_async_reset();
    cyc(1, 1, 2, 0, "ar0");
    cyc(1, 1, 3, 0, "ar1");
    @(negedge clk); a_lv = 0;
    #2; rst = 1; #1;
    checks++;
    if ({a_cards, a_count, a_score, a_full, a_nat, a_err} !== '0)
      $display("FAIL async_reset got %h want 0", {a_cards, a_count, a_score, a_full, a_nat, a_err});
    else passes++;
    m_clear();
    @(negedge clk); rst = 0;
    cyc(1, 1, 6, 0, "ar_after");
    checks++;
    if (a_cards[15:12] !== 4'd6 || a_score[7:4] !== 4'd6)
      $display("FAIL ar_slot0 got card %0d score %0d want 6 6", a_cards[15:12], a_score[7:4]);
    else passes++;
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 8 == 0) begin
        c = $urandom % 3;
        c = (c == 0) ? 0 : 13 + c;
      end else c = 1 + $urandom % 13;
      cyc(($urandom % 4) != 0, $urandom % 4, c, ($urandom % 20) == 0, "rand");
    end
  endtask

  task automatic test_sweep();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); b_lv = 1; b_lh = 2'd3; b_nc = 4'(i);
    end
    @(negedge clk); b_nc = 4'd7; #1;
    checks++; if (b_ready !== 1'b0) $display("FAIL sweep_ready got %b want 0", b_ready); else passes++;
    checks++; if (b_score[15:12] !== 4'd5) $display("FAIL sweep_score got %0d want 5", b_score[15:12]); else passes++;
    checks++; if (b_full !== 4'b1000) $display("FAIL sweep_full got %b want 1000", b_full); else passes++;
    checks++; if (b_count[11:9] !== 3'd5) $display("FAIL sweep_count got %0d want 5", b_count[11:9]); else passes++;
    checks++; if (b_cards[79:60] !== 20'h54321) $display("FAIL sweep_cards got %h want 54321", b_cards[79:60]); else passes++;
    checks++;
    if (b_cards[59:0] !== '0 || b_count[8:0] !== '0 || b_score[11:0] !== '0 || b_err !== 1'b0)
      $display("FAIL sweep_others got %h want 0", {b_cards[59:0], b_count[8:0], b_score[11:0], b_err});
    else passes++;
    @(posedge clk); #1;
    checks++; if (b_cards[79:60] !== 20'h54321) $display("FAIL sweep_hold got %h want 54321", b_cards[79:60]); else passes++;
    @(negedge clk); b_lv = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_natural();
    test_err();
    test_clear_collision();
    test_async_reset();
    test_random();
    test_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
